// File: rtl/stream_accumulator_pkg.sv
// Shared types and defaults for the stream accumulator: FSM state encoding and
// the default operand, accumulator and beat-counter widths.
package stream_accumulator_pkg;

    localparam int unsigned DEF_WIDTH     = 8;
    localparam int unsigned DEF_ACC_WIDTH = 16;
    localparam int unsigned DEF_CNT_WIDTH = 8;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StAccum = 2'd1,
        StDone  = 2'd2
    } state_e;

endpackage

// File: rtl/stream_accumulator_if.sv
// Operand-in / result-out handshake bundle for the stream accumulator.
// The accumulator takes the slave side; the producer/consumer takes master.
interface stream_accumulator_if
    import stream_accumulator_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned ACC_WIDTH = DEF_ACC_WIDTH,
    parameter int unsigned CNT_WIDTH = DEF_CNT_WIDTH
) ();

    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_data;
    logic                 in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_WIDTH-1:0] out_sum;
    logic [CNT_WIDTH-1:0] out_count;
    logic                 out_ovf;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_ovf
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_ovf
    );

endinterface

// File: rtl/stream_accumulator_cla4_slice.sv
// 4-bit carry-lookahead adder slice; slices are chained through cin/cout to
// form the accumulate adder.
module stream_accumulator_cla4_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    assign g = a & b;
    assign p = a ^ b;

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign s = p ^ c;

endmodule

// File: rtl/stream_accumulator.sv
// Accumulates a valid/ready stream of unsigned operands and, once the beat
// flagged last is taken, presents total, saturating beat count and sticky carry.
module stream_accumulator
    import stream_accumulator_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned ACC_WIDTH = DEF_ACC_WIDTH,
    parameter int unsigned CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    stream_accumulator_if.slave  bus
);

    localparam int unsigned NumSlices = ACC_WIDTH / 4;
    localparam logic [CNT_WIDTH-1:0] CntMax = '1;

    state_e               state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 ovf_q, ovf_d;
    logic                 rst_done_q;

    logic                 in_rdy;
    logic                 out_vld;
    logic [ACC_WIDTH-1:0] operand;
    logic [ACC_WIDTH-1:0] sum;
    logic [NumSlices:0]   carry;

    assign operand  = ACC_WIDTH'(bus.in_data);
    assign carry[0] = 1'b0;

    for (genvar i = 0; i < NumSlices; i++) begin : gen_slice
        stream_accumulator_cla4_slice u_slice (
            .a    (acc_q[4*i +: 4]),
            .b    (operand[4*i +: 4]),
            .cin  (carry[i]),
            .s    (sum[4*i +: 4]),
            .cout (carry[i+1])
        );
    end

    // Holds in_ready low until the first edge after reset is released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_done_q <= 1'b0;
        end else begin
            rst_done_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            acc_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        in_rdy  = 1'b0;
        out_vld = 1'b0;

        // clear masks both handshakes so nothing is taken or delivered that cycle.
        if (clear) begin
            state_d = StIdle;
            acc_d   = '0;
            count_d = '0;
            ovf_d   = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    in_rdy = rst_done_q;
                    if (bus.in_valid && in_rdy) begin
                        acc_d   = operand;
                        count_d = CNT_WIDTH'(1);
                        ovf_d   = 1'b0;
                        state_d = bus.in_last ? StDone : StAccum;
                    end
                end
                StAccum: begin
                    in_rdy = 1'b1;
                    if (bus.in_valid) begin
                        acc_d   = sum;
                        ovf_d   = ovf_q | carry[NumSlices];
                        count_d = (count_q == CntMax) ? count_q : count_q + CNT_WIDTH'(1);
                        state_d = bus.in_last ? StDone : StAccum;
                    end
                end
                StDone: begin
                    out_vld = 1'b1;
                    if (bus.out_ready) begin
                        state_d = StIdle;
                        acc_d   = '0;
                        count_d = '0;
                        ovf_d   = 1'b0;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = out_vld;
    assign bus.out_sum   = out_vld ? acc_q : '0;
    assign bus.out_count = out_vld ? count_q : '0;
    assign bus.out_ovf   = out_vld & ovf_q;

endmodule

// File: tb/tb_stream_accumulator.sv
// Scoreboard bench for stream_accumulator: directed scenarios plus randomized
// streams, checked against an arithmetic model of each stream's total.
module tb_stream_accumulator;

    localparam int unsigned W  = 8;
    localparam int unsigned AW = 8;
    localparam int unsigned CW = 4;
    localparam int AccMod = 1 << AW;
    localparam int CntMax = (1 << CW) - 1;

    typedef struct {
        int sum;
        int count;
        int ovf;
    } exp_t;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic clear = 1'b0;

    stream_accumulator_if #(.WIDTH(W), .ACC_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

    stream_accumulator #(.WIDTH(W), .ACC_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   total = 0;
    int   nbeats = 0;
    int   n_expected = 0;
    int   n_seen = 0;
    int   w;
    bit   gen_done = 1'b0;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: a stream's result is its plain integer total, reduced modulo
    // the accumulator range, with overflow meaning the total left that range.
    task automatic model_accept(input int d, input bit last);
        exp_t e;
        total += d;
        nbeats++;
        if (last) begin
            e.sum   = total % AccMod;
            e.count = (nbeats > CntMax) ? CntMax : nbeats;
            e.ovf   = (total >= AccMod) ? 1 : 0;
            exp_q.push_back(e);
            n_expected++;
            total  = 0;
            nbeats = 0;
        end
    endtask

    task automatic model_flush();
        n_expected -= exp_q.size();
        exp_q.delete();
        total  = 0;
        nbeats = 0;
    endtask

    // Presents one beat and returns after the edge that takes it.
    task automatic send_beat(input int d, input bit last, output int waits);
        waits = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = W'(d);
        bus.in_last  = last;
        forever begin
            @(negedge clk);
            if (bus.in_ready && !clear) break;
            waits++;
            if (waits > 200) break;
        end
        if (waits > 200) begin
            check("beat_accept_timeout", waits, 0);
            bus.in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            model_accept(d, last);
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic check_out(input string name, input int v, input int s, input int c,
                             input int o);
        check({name, "_valid"}, int'(bus.out_valid), v);
        check({name, "_sum"},   int'(bus.out_sum),   s);
        check({name, "_count"}, int'(bus.out_count), c);
        check({name, "_ovf"},   int'(bus.out_ovf),   o);
    endtask

    // Monitor: pops the scoreboard on every consumed result.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.out_valid && bus.out_ready) begin
                n_seen++;
                if (exp_q.size() == 0) begin
                    check("result_unexpected", int'(bus.out_sum), -1);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("sb_sum",   int'(bus.out_sum),   mon_e.sum);
                    check("sb_count", int'(bus.out_count), mon_e.count);
                    check("sb_ovf",   int'(bus.out_ovf),   mon_e.ovf);
                end
            end else if (!bus.out_valid) begin
                check("idle_outputs_zero",
                      int'(bus.out_sum) + int'(bus.out_count) + int'(bus.out_ovf), 0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;

        // Reset and idle
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_in_ready_before_edge", int'(bus.in_ready), 0);
        @(posedge clk);
        #1;
        check("rst_in_ready", int'(bus.in_ready), 1);
        check_out("rst", 0, 0, 0, 0);

        // Basic stream
        bus.out_ready = 1'b1;
        send_beat(10, 1'b0, w);
        send_beat(20, 1'b0, w);
        send_beat(30, 1'b1, w);
        check_out("basic", 1, 60, 3, 0);
        @(posedge clk);
        #1;
        check("basic_consumed_valid", int'(bus.out_valid), 0);

        // Overflow
        send_beat(200, 1'b0, w);
        send_beat(100, 1'b1, w);
        check_out("ovf", 1, 44, 2, 1);
        @(posedge clk);
        #1;

        // Backpressure
        bus.out_ready = 1'b0;
        send_beat(255, 1'b1, w);
        bus.in_valid = 1'b1;
        bus.in_data  = W'(7);
        bus.in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_in_ready", int'(bus.in_ready), 0);
            check("bp_sum", int'(bus.out_sum), 255);
            check("bp_count", int'(bus.out_count), 1);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        send_beat(7, 1'b1, w);
        check("bp_wait_cycles", w, 1);
        check_out("bp_seven", 1, 7, 1, 0);
        @(posedge clk);
        #1;

        // Count saturation
        for (int i = 0; i < 20; i++) send_beat(1, i == 19, w);
        check_out("sat", 1, 20, 15, 0);
        @(posedge clk);
        #1;

        // Abort by clear
        send_beat(5, 1'b0, w);
        send_beat(6, 1'b0, w);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        model_flush();
        check("clr_valid", int'(bus.out_valid), 0);
        send_beat(9, 1'b1, w);
        check_out("clr", 1, 9, 1, 0);
        @(posedge clk);
        #1;

        // Abort by asynchronous reset pulse between edges
        send_beat(5, 1'b0, w);
        send_beat(6, 1'b0, w);
        #1;
        rst = 1'b1;
        #1;
        check("arst_in_ready", int'(bus.in_ready), 0);
        #1;
        rst = 1'b0;
        model_flush();
        send_beat(9, 1'b1, w);
        check("arst_wait_cycles", w, 1);
        check_out("arst", 1, 9, 1, 0);
        @(posedge clk);
        #1;

        // Reset while holding a result
        bus.out_ready = 1'b0;
        send_beat(3, 1'b1, w);
        check("rst_done_valid_before", int'(bus.out_valid), 1);
        #1;
        rst = 1'b1;
        #1;
        rst = 1'b0;
        model_flush();
        @(negedge clk);
        check_out("rst_done_dropped", 0, 0, 0, 0);

        // Clear while holding a result
        send_beat(4, 1'b1, w);
        check("clr_done_valid_before", int'(bus.out_valid), 1);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        model_flush();
        @(negedge clk);
        check_out("clr_done_dropped", 0, 0, 0, 0);
        @(posedge clk);
        #1;

        // Randomized streams with input gaps and random backpressure
        fork
            begin
                int len;
                int gap;
                for (int s = 0; s < 30; s++) begin
                    len = int'($urandom_range(1, 22));
                    for (int b = 0; b < len; b++) begin
                        gap = int'($urandom_range(0, 2));
                        for (int g = 0; g < gap; g++) begin
                            bus.in_valid = 1'b0;
                            bus.in_last  = 1'($urandom_range(0, 1));
                            bus.in_data  = W'($urandom);
                            @(posedge clk);
                            #1;
                        end
                        send_beat(int'($urandom_range(0, 255)), b == len - 1, w);
                    end
                end
                gen_done = 1'b1;
            end
            begin
                while (!gen_done) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join

        bus.out_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("drain_queue_empty", exp_q.size(), 0);
        check("results_delivered", n_seen, n_expected);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/stream_accumulator.md
Name: stream_accumulator

Overview:
- Downstream consumer of the 8-bit parallel adder datapath.
- Accepts a stream of unsigned WIDTH-bit operands over a valid/ready handshake and accumulates them into an ACC_WIDTH-bit register.
- The accumulate adder is built structurally from a chain of 4-bit carry-lookahead slices.
- When the input beat flagged last is accepted, the block presents the total, a beat count and a sticky overflow flag on an output handshake.

Parameters:
- WIDTH, 8: operand width in bits. Must be a multiple of 4 and ≤ ACC_WIDTH.
- ACC_WIDTH, 16: accumulator width in bits. Must be a multiple of 4.
- CNT_WIDTH, 8: beat-counter width in bits. The counter saturates at 2^CNT_WIDTH-1.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous abort; returns the block to IDLE.
- in_valid  input  1  operand beat present.
- in_ready  output  1  block can accept a beat.
- in_data  input  WIDTH  unsigned operand.
- in_last  input  1  final beat of the current stream.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- out_sum  output  ACC_WIDTH  accumulated total, modulo 2^ACC_WIDTH.
- out_count  output  CNT_WIDTH  number of beats accepted, saturating.
- out_ovf  output  1  sticky flag: a carry out of the MSB occurred during this stream.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - acc=0, count=0, ovf=0.
  - out_valid=0; out_sum, out_count and out_ovf read 0.
  - in_ready goes to 1 on the first clock edge after rst deasserts.
- Transfers: a beat is accepted when in_valid && in_ready at a rising edge. A result is consumed when out_valid && out_ready at a rising edge.
- State IDLE:
  - in_ready=1, out_valid=0.
  - On accept: acc=zext(in_data), count=1, ovf=0.
  - Next state is DONE if in_last, otherwise ACCUM.
- State ACCUM:
  - in_ready=1, out_valid=0.
  - On accept: {c,acc} = acc + zext(in_data); ovf |= c; count = min(count+1, 2^CNT_WIDTH-1).
  - Next state is DONE if in_last, otherwise stay in ACCUM.
  - With no beat, state is held.
- State DONE:
  - in_ready=0, out_valid=1.
  - out_sum=acc, out_count=count, out_ovf=ovf, all stable until consumed.
  - On consume: go to IDLE and zero acc, count and ovf in the same edge.
- Latency:
  - out_valid rises on the edge that accepts the last beat, i.e. it is visible in the cycle after the handshake.
  - One accumulate per cycle; throughput is 1 beat/clk.
  - Minimum one bubble between streams: in_ready is 0 during DONE, so the next stream's first beat cannot be accepted on the consume edge.
- out_sum, out_count and out_ovf read 0 whenever out_valid=0.
- Arithmetic:
  - Unsigned only; in_data is zero-extended to ACC_WIDTH.
  - The adder carry-in is 0.
  - The ACC_WIDTH/4 slices ripple their group carry between slices.
  - The final group carry-out drives ovf.
- Boundary conditions:
  - in_valid=1 with in_ready=0: no accept, no state change.
  - out_ready held 0: DONE is held indefinitely with stable outputs.
  - A stream of length 1 (in_last on the first beat) goes IDLE→DONE directly.
  - The counter stops at its maximum value; acc continues to wrap.
  - clear=1: state goes to IDLE and acc, count, ovf are zeroed. No beat is accepted that cycle and any in-flight result is dropped. clear has priority over all handshakes.
  - rst mid-stream or mid-DONE: immediate abort. The partial stream is discarded and no output is produced.
  - in_last=1 with in_valid=0 is ignored.

Decomposition:
- Shared package: state encoding constants for IDLE, ACCUM and DONE (2-bit); default WIDTH, ACC_WIDTH and CNT_WIDTH values.
- Sub-module cla4_slice:
  - Inputs: a[3:0], b[3:0], cin.
  - Outputs: s[3:0], cout.
  - Logic: gi=ai&bi, pi=ai^bi; carries c1..c4 by lookahead equations; si=pi^ci.
  - Purely combinational, instantiated ACC_WIDTH/4 times in the top module.
- The top module holds the FSM, the acc/count/ovf registers and the handshake logic.

Test Plan:
1. Reset and idle: assert rst for 3 cycles, then release → out_valid=0, out_sum=0, in_ready=1 on the next edge.
2. Basic stream: beats 10, 20, 30 with in_last on 30, out_ready=1 → one cycle later out_valid=1, out_sum=60, out_count=3, out_ovf=0; next cycle out_valid=0.
3. Overflow (ACC_WIDTH=8): beats 200, 100(last) → out_sum=44, out_ovf=1, out_count=2.
4. Backpressure: stream of 0xFF(last), out_ready=0 for 5 cycles while in_valid=1 with data 7 → out_sum stays 255, out_count=1, in_ready=0 throughout, the 7 is not absorbed; then out_ready=1 → IDLE, and the 7 is accepted as a new stream on the following edge.
5. Count saturation (CNT_WIDTH=4): 20 beats of 1 → out_count=15, out_sum=20, out_ovf=0.
6. Abort: beats 5, 6, then clear=1 for one cycle, then beat 9(last) → out_sum=9, out_count=1. Repeat the sequence with an async rst pulse between cycle edges in place of clear → identical result.
